// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        UPDATE
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Index fields that may collapse to zero bits (e.g. one way) keep one bit
    function automatic int width1(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set age counters for LRU replacement; age 0 is most recent, the oldest way is the victim.
module dcache_lru
    import dcache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [clog2(SETS)-1:0]            set,
    input  logic [width1(clog2(WAYS))-1:0]    way,
    input  logic                              touch,
    output logic [width1(clog2(WAYS))-1:0]    victim
);

    localparam int IDX_W = clog2(SETS);
    localparam int WAY_W = width1(clog2(WAYS));
    localparam int AGE_W = width1(clog2(WAYS));
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    logic [AGE_W-1:0] age_q [SETS][WAYS];
    logic [AGE_W-1:0] age_d [SETS][WAYS];
    logic [AGE_W-1:0] old_age;
    logic [AGE_W-1:0] best_age;

    // '<=' rather than '<' lets the all-zero reset state settle into distinct ages
    always_comb begin
        age_d   = age_q;
        old_age = age_q[set][way];
        if (touch) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == way) begin
                    age_d[set][w] = '0;
                end else if (age_q[set][w] <= old_age && age_q[set][w] != AGE_MAX) begin
                    age_d[set][w] = age_q[set][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim   = '0;
        best_age = age_q[set][0];
        for (int unsigned w = 1; w < WAYS; w++) begin
            if (age_q[set][w] > best_age) begin
                best_age = age_q[set][w];
                victim   = WAY_W'(w);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= '0;
                end
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache with LRU replacement and hit/miss counters.
module dcache_assoc
    import dcache_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WORD_W      = 8,
    parameter int BLOCK_WORDS = 4,
    parameter int SETS        = 8,
    parameter int WAYS        = 2,
    parameter int CNT_W       = 16
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        read,
    input  logic                                        write,
    input  logic [ADDR_W-1:0]                           address,
    input  logic [WORD_W-1:0]                           writedata,
    output logic [WORD_W-1:0]                           readdata,
    output logic                                        busywait,
    output logic                                        mem_read,
    output logic                                        mem_write,
    output logic [ADDR_W-clog2(BLOCK_WORDS)-1:0]        mem_address,
    output logic [WORD_W*BLOCK_WORDS-1:0]               mem_writedata,
    input  logic [WORD_W*BLOCK_WORDS-1:0]               mem_readdata,
    input  logic                                        mem_busywait,
    output logic [CNT_W-1:0]                            hit_count,
    output logic [CNT_W-1:0]                            miss_count
);

    localparam int OFF_W   = clog2(BLOCK_WORDS);
    localparam int IDX_W   = clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int WAY_W   = width1(clog2(WAYS));
    localparam int BLOCK_W = WORD_W * BLOCK_WORDS;

    logic [BLOCK_W-1:0] data_q  [SETS][WAYS];
    logic [BLOCK_W-1:0] data_d  [SETS][WAYS];
    logic [TAG_W-1:0]   tag_q   [SETS][WAYS];
    logic [TAG_W-1:0]   tag_d   [SETS][WAYS];
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    logic [WAYS-1:0]    dirty_q [SETS];
    logic [WAYS-1:0]    dirty_d [SETS];

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [OFF_W-1:0]   addr_off;
    logic               req;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_found;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   lru_victim;
    logic [WAY_W-1:0]   victim_sel;
    logic               touch;

    assign addr_tag = address[ADDR_W-1 -: TAG_W];
    assign addr_idx = address[OFF_W +: IDX_W];
    assign addr_off = address[OFF_W-1:0];
    assign req      = read | write;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[addr_idx][w] && tag_q[addr_idx][w] == addr_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[addr_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_sel = inv_found ? inv_way : lru_victim;
    assign touch      = (state_q == IDLE) && req && hit;

    dcache_lru #(
        .SETS (SETS),
        .WAYS (WAYS)
    ) u_lru (
        .clock  (clock),
        .reset  (reset),
        .set    (addr_idx),
        .way    (hit_way),
        .touch  (touch),
        .victim (lru_victim)
    );

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        hit_count_d   = hit_count_q;
        miss_count_d  = miss_count_q;
        data_d        = data_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        readdata      = '0;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;

        case (state_q)
            IDLE: begin
                if (req && hit) begin
                    readdata = data_q[addr_idx][hit_way][addr_off*WORD_W +: WORD_W];
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 1'b1;
                    if (write) begin
                        data_d[addr_idx][hit_way][addr_off*WORD_W +: WORD_W] = writedata;
                        dirty_d[addr_idx][hit_way] = 1'b1;
                    end
                end else if (req) begin
                    busywait = 1'b1;
                    victim_d = victim_sel;
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 1'b1;
                    if (valid_q[addr_idx][victim_sel] && dirty_q[addr_idx][victim_sel]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_q[addr_idx][victim_q], addr_idx};
                mem_writedata = data_q[addr_idx][victim_q];
                if (!mem_busywait) state_d = REFILL;
            end
            REFILL: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {addr_tag, addr_idx};
                if (!mem_busywait) state_d = UPDATE;
            end
            UPDATE: begin
                busywait                   = 1'b1;
                data_d[addr_idx][victim_q]  = mem_readdata;
                tag_d[addr_idx][victim_q]   = addr_tag;
                valid_d[addr_idx][victim_q] = 1'b1;
                dirty_d[addr_idx][victim_q] = 1'b0;
                state_d                    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    data_q[s][w] <= '0;
                    tag_q[s][w]  <= '0;
                end
            end
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            data_q       <= data_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_dcache_assoc.sv
// Bench for dcache_assoc: 2-way default build plus a direct-mapped build, each on a 5-cycle block memory model.
module tb_dcache_assoc;

    localparam int LAT = 5;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         stall;
        bit         wb;
        logic [5:0] wb_addr;
        logic [5:0] rf_addr;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [7:0]  addr_s  [2];
    logic [7:0]  wdata_s [2];
    logic [7:0]  rdata   [2];
    logic        bw      [2];
    logic        mrd     [2];
    logic        mwr     [2];
    logic [5:0]  maddr   [2];
    logic [31:0] mwdata  [2];
    logic [31:0] mrdata  [2];
    logic        mbw     [2];
    logic [15:0] hits    [2];
    logic [15:0] misses  [2];

    logic [31:0] mem [2][64];
    int          cnt [2];
    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_q [$];
    int          exp_hit  [2];
    int          exp_miss [2];
    int          n_checks;
    int          n_fail;
    vec_t        vecs [12];

    dcache_assoc #(
        .ADDR_W(8), .WORD_W(8), .BLOCK_WORDS(4), .SETS(8), .WAYS(2), .CNT_W(16)
    ) u_dut (
        .clock(clock), .reset(reset), .read(rd_s[0]), .write(wr_s[0]),
        .address(addr_s[0]), .writedata(wdata_s[0]), .readdata(rdata[0]),
        .busywait(bw[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
        .mem_address(maddr[0]), .mem_writedata(mwdata[0]), .mem_readdata(mrdata[0]),
        .mem_busywait(mbw[0]), .hit_count(hits[0]), .miss_count(misses[0])
    );

    dcache_assoc #(
        .ADDR_W(8), .WORD_W(8), .BLOCK_WORDS(4), .SETS(8), .WAYS(1), .CNT_W(16)
    ) u_dm (
        .clock(clock), .reset(reset), .read(rd_s[1]), .write(wr_s[1]),
        .address(addr_s[1]), .writedata(wdata_s[1]), .readdata(rdata[1]),
        .busywait(bw[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
        .mem_address(maddr[1]), .mem_writedata(mwdata[1]), .mem_readdata(mrdata[1]),
        .mem_busywait(mbw[1]), .hit_count(hits[1]), .miss_count(misses[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_blk(input int b);
        return 32'h44332211 + 32'h01010101 * b;
    endfunction

    // Block memory: a request completes at the LAT-th posedge it is held
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                cnt[p]    <= 0;
                mrdata[p] <= '0;
                for (int b = 0; b < 64; b++) mem[p][b] <= init_blk(b);
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (mrd[p] || mwr[p]) begin
                    if (cnt[p] == LAT - 1) begin
                        cnt[p] <= 0;
                        if (mrd[p]) mrdata[p] <= mem[p][maddr[p]];
                        if (mwr[p]) mem[p][maddr[p]] <= mwdata[p];
                    end else begin
                        cnt[p] <= cnt[p] + 1;
                    end
                end else begin
                    cnt[p] <= 0;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) mbw[p] = !((mrd[p] || mwr[p]) && cnt[p] == LAT - 1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic ref_init();
        logic [31:0] blk;
        for (int b = 0; b < 64; b++) begin
            blk = init_blk(b);
            for (int k = 0; k < 4; k++) ref_mem[b*4+k] = blk[k*8 +: 8];
        end
    endtask

    // Entered and left on a negedge with the request lines low
    task automatic access(input int p, input vec_t v);
        logic [31:0] exp_wbd;
        logic [31:0] wbd;
        logic [5:0]  wba;
        logic [5:0]  rfa;
        logic [7:0]  e;
        int          stall;
        bit          saw_wb;
        int          base;
        base    = int'(v.wb_addr) * 4;
        exp_wbd = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        if (v.wr) ref_mem[v.addr] = v.wdata;
        else      exp_q.push_back(ref_mem[v.addr]);
        rd_s[p]    = !v.wr;
        wr_s[p]    = v.wr;
        addr_s[p]  = v.addr;
        wdata_s[p] = v.wdata;
        #1;
        stall = 0; saw_wb = 0; wba = '0; rfa = '0; wbd = '0;
        while (bw[p] === 1'b1 && stall < 200) begin
            if (mwr[p]) begin
                saw_wb = 1'b1;
                wba    = maddr[p];
                wbd    = mwdata[p];
            end
            if (mrd[p]) rfa = maddr[p];
            @(negedge clock);
            #1;
            stall++;
        end
        chk($sformatf("stall@%0h", v.addr), 32'(stall), 32'(v.stall));
        if (!v.wr) begin
            e = exp_q.pop_front();
            chk($sformatf("readdata@%0h", v.addr), 32'(rdata[p]), 32'(e));
        end
        chk($sformatf("writeback@%0h", v.addr), 32'(saw_wb), 32'(v.wb));
        if (v.wb) begin
            chk($sformatf("wb_addr@%0h", v.addr), 32'(wba), 32'(v.wb_addr));
            chk($sformatf("wb_data@%0h", v.addr), wbd, exp_wbd);
        end
        if (v.stall > 0) begin
            chk($sformatf("refill_addr@%0h", v.addr), 32'(rfa), 32'(v.rf_addr));
            exp_miss[p]++;
        end
        exp_hit[p]++;
        @(negedge clock);
        rd_s[p] = 1'b0;
        wr_s[p] = 1'b0;
    endtask

    function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                input int st, input bit wb, input logic [5:0] wa,
                                input logic [5:0] ra);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.stall = st;
        v.wb = wb; v.wb_addr = wa; v.rf_addr = ra;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int p = 0; p < 2; p++) begin
            rd_s[p] = 1'b0; wr_s[p] = 1'b0; addr_s[p] = '0; wdata_s[p] = '0;
            exp_hit[p] = 0; exp_miss[p] = 0;
        end
        // clean miss = LAT+2 stall cycles, dirty miss = 2*LAT+2
        vecs[0]  = mk(0, 8'h00, 8'h00,  7, 0, 6'h00, 6'h00);
        vecs[1]  = mk(0, 8'h03, 8'h00,  0, 0, 6'h00, 6'h00);
        vecs[2]  = mk(0, 8'h20, 8'h00,  7, 0, 6'h00, 6'h08);
        vecs[3]  = mk(1, 8'h00, 8'hAA,  0, 0, 6'h00, 6'h00);
        vecs[4]  = mk(0, 8'h40, 8'h00,  7, 0, 6'h00, 6'h10);
        vecs[5]  = mk(0, 8'h20, 8'h00, 12, 1, 6'h00, 6'h08);
        vecs[6]  = mk(0, 8'h01, 8'h00,  7, 0, 6'h00, 6'h00);
        vecs[7]  = mk(1, 8'h41, 8'h5B,  7, 0, 6'h00, 6'h10);
        vecs[8]  = mk(0, 8'h41, 8'h00,  0, 0, 6'h00, 6'h00);
        vecs[9]  = mk(0, 8'h07, 8'h00,  7, 0, 6'h00, 6'h01);
        vecs[10] = mk(1, 8'h22, 8'h77,  7, 0, 6'h00, 6'h08);
        vecs[11] = mk(0, 8'h02, 8'h00, 12, 1, 6'h10, 6'h00);
        ref_init();

        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_busywait",  32'(bw[0]),     32'h0);
        chk("rst_mem_read",  32'(mrd[0]),    32'h0);
        chk("rst_mem_write", 32'(mwr[0]),    32'h0);
        chk("rst_mem_addr",  32'(maddr[0]),  32'h0);
        chk("rst_mem_wdata", mwdata[0],      32'h0);
        chk("rst_readdata",  32'(rdata[0]),  32'h0);
        chk("rst_hits",      32'(hits[0]),   32'h0);
        chk("rst_misses",    32'(misses[0]), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 12; i++) access(0, vecs[i]);
        chk("hit_count",  32'(hits[0]),   32'(exp_hit[0]));
        chk("miss_count", 32'(misses[0]), 32'(exp_miss[0]));

        // Reset in the middle of a refill must drop the memory request at once
        rd_s[0]   = 1'b1;
        addr_s[0] = 8'h24;
        repeat (3) @(negedge clock);
        chk("pre_reset_mem_read", 32'(mrd[0]), 32'h1);
        #2;
        reset   = 1'b1;
        rd_s[0] = 1'b0;
        #1;
        chk("midrst_mem_read", 32'(mrd[0]),    32'h0);
        chk("midrst_busywait", 32'(bw[0]),     32'h0);
        chk("midrst_mem_addr", 32'(maddr[0]),  32'h0);
        chk("midrst_misses",   32'(misses[0]), 32'h0);
        chk("midrst_hits",     32'(hits[0]),   32'h0);
        @(negedge clock);
        reset = 1'b0;
        ref_init();
        exp_hit[0]  = 0;
        exp_miss[0] = 0;
        @(negedge clock);
        access(0, mk(0, 8'h00, 8'h00, 7, 0, 6'h00, 6'h00));
        chk("post_reset_misses", 32'(misses[0]), 32'(exp_miss[0]));

        // Direct-mapped build: 0x00 and 0x20 share the only way of set 0
        access(1, mk(0, 8'h00, 8'h00, 7, 0, 6'h00, 6'h00));
        access(1, mk(0, 8'h20, 8'h00, 7, 0, 6'h00, 6'h08));
        access(1, mk(0, 8'h00, 8'h00, 7, 0, 6'h00, 6'h00));
        access(1, mk(0, 8'h20, 8'h00, 7, 0, 6'h00, 6'h08));
        chk("dm_miss_count", 32'(misses[1]), 32'(exp_miss[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
